// File: rtl/attack_sequencer_pkg.sv
// Shared game types for the per-player attack sequencer.
// Attack kinds, phases and default phase lengths.
package attack_sequencer_pkg;

  typedef enum logic [1:0] {
    ATK_NONE,
    NEUTRAL,
    SIDE,
    AIR
  } attack_state;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STARTUP,
    S_ACTIVE,
    S_RECOVERY,
    S_COOLDOWN
  } atk_phase_t;

  localparam int DEF_STARTUP_TICKS  = 2;
  localparam int DEF_ACTIVE_TICKS   = 3;
  localparam int DEF_RECOVERY_TICKS = 4;
  localparam int DEF_COOLDOWN_TICKS = 2;

  localparam logic [3:0] FRAME_MAX = 4'd15;

  function automatic attack_state pick_kind(
    input logic grounded,
    input logic dir_held
  );
    if (!grounded) return AIR;
    if (dir_held) return SIDE;
    return NEUTRAL;
  endfunction

endpackage

// File: rtl/attack_sequencer_phase_timer.sv
// Phase length counter: load on phase entry, count down on ticks.
// zero flags the last tick of the current phase.
module phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       tick,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/attack_sequencer.sv
// Per-player attack controller: STARTUP -> ACTIVE -> RECOVERY -> COOLDOWN.
// Edge-detected button, one-deep press buffer, hit_stun abort.
module attack_sequencer
  import attack_sequencer_pkg::*;
#(
  parameter int STARTUP_TICKS  = DEF_STARTUP_TICKS,
  parameter int ACTIVE_TICKS   = DEF_ACTIVE_TICKS,
  parameter int RECOVERY_TICKS = DEF_RECOVERY_TICKS,
  parameter int COOLDOWN_TICKS = DEF_COOLDOWN_TICKS,
  parameter bit BUFFER_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        anim_tick,
  input  logic        atk_btn,
  input  logic        dir_held,
  input  logic        grounded,
  input  logic        hit_stun,
  output logic        attack_active,
  output attack_state atk_state,
  output logic        hitbox_active,
  output logic        anim_restart,
  output logic [3:0]  atk_frame
);

  localparam logic [3:0] ST_LD = 4'(STARTUP_TICKS - 1);
  localparam logic [3:0] AC_LD = 4'(ACTIVE_TICKS - 1);
  localparam logic [3:0] RC_LD = 4'(RECOVERY_TICKS - 1);
  localparam logic [3:0] CD_LD = 4'(COOLDOWN_TICKS - 1);

  atk_phase_t phase;
  atk_phase_t nxt;
  logic [3:0] nxt_ld;
  logic [3:0] load_val;
  logic       btn_q;
  logic       pending;
  logic       press;
  logic       start;
  logic       adv;
  logic       cap;
  logic       busy_tick;
  logic       t_zero;
  logic       t_load;

  assign press     = atk_btn & ~btn_q;
  assign busy_tick = anim_tick & ~hit_stun & (phase != S_IDLE);
  assign start     = anim_tick & ~hit_stun & pending & (phase == S_IDLE);
  assign adv       = busy_tick & t_zero;

  // A press on the start cycle is swallowed by the attack it would have queued.
  assign cap = press & ~hit_stun & ~start &
               ((phase == S_IDLE) ||
                (BUFFER_EN && (phase == S_RECOVERY || phase == S_COOLDOWN)));

  always_comb begin
    nxt    = S_IDLE;
    nxt_ld = 4'd0;
    unique case (phase)
      S_STARTUP:  begin nxt = S_ACTIVE;   nxt_ld = AC_LD; end
      S_ACTIVE:   begin nxt = S_RECOVERY; nxt_ld = RC_LD; end
      S_RECOVERY: begin nxt = S_COOLDOWN; nxt_ld = CD_LD; end
      default:    begin nxt = S_IDLE;     nxt_ld = 4'd0;  end
    endcase
  end

  assign t_load   = hit_stun | start | adv;
  assign load_val = hit_stun ? 4'd0 : start ? ST_LD : nxt_ld;

  phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (load_val),
    .tick     (busy_tick),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase         <= S_IDLE;
      btn_q         <= 1'b0;
      pending       <= 1'b0;
      attack_active <= 1'b0;
      atk_state     <= ATK_NONE;
      hitbox_active <= 1'b0;
      anim_restart  <= 1'b0;
      atk_frame     <= 4'd0;
    end else begin
      btn_q        <= atk_btn;
      anim_restart <= 1'b0;
      if (hit_stun) begin
        phase         <= S_IDLE;
        pending       <= 1'b0;
        atk_state     <= ATK_NONE;
        attack_active <= 1'b0;
        hitbox_active <= 1'b0;
      end else begin
        if (cap) pending <= 1'b1;
        if (anim_tick && attack_active && atk_frame != FRAME_MAX)
          atk_frame <= atk_frame + 4'd1;
        if (start) begin
          phase         <= S_STARTUP;
          pending       <= 1'b0;
          atk_state     <= pick_kind(grounded, dir_held);
          atk_frame     <= 4'd0;
          anim_restart  <= 1'b1;
          attack_active <= 1'b1;
          hitbox_active <= 1'b0;
        end else if (adv) begin
          phase         <= nxt;
          attack_active <= (nxt == S_ACTIVE) || (nxt == S_RECOVERY);
          hitbox_active <= (nxt == S_ACTIVE);
          if (nxt == S_COOLDOWN) atk_state <= ATK_NONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_attack_sequencer.sv
// Bench for attack_sequencer: three configurations driven in lockstep
// against a tick-timeline reference model, plus table and hand sequences.
module tb_attack_sequencer;
  import attack_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic anim_tick = 1'b0;
  logic atk_btn = 1'b0;
  logic dir_held = 1'b0;
  logic grounded = 1'b1;
  logic hit_stun = 1'b0;

  logic        aa [3];
  attack_state st [3];
  logic        hb [3];
  logic        rs [3];
  logic [3:0]  fr [3];

  always #5 clk = ~clk;

  attack_sequencer u0 (
    .clk(clk), .reset(reset), .anim_tick(anim_tick), .atk_btn(atk_btn),
    .dir_held(dir_held), .grounded(grounded), .hit_stun(hit_stun),
    .attack_active(aa[0]), .atk_state(st[0]), .hitbox_active(hb[0]),
    .anim_restart(rs[0]), .atk_frame(fr[0]));

  attack_sequencer #(.BUFFER_EN(1'b0)) u1 (
    .clk(clk), .reset(reset), .anim_tick(anim_tick), .atk_btn(atk_btn),
    .dir_held(dir_held), .grounded(grounded), .hit_stun(hit_stun),
    .attack_active(aa[1]), .atk_state(st[1]), .hitbox_active(hb[1]),
    .anim_restart(rs[1]), .atk_frame(fr[1]));

  attack_sequencer #(.STARTUP_TICKS(15)) u2 (
    .clk(clk), .reset(reset), .anim_tick(anim_tick), .atk_btn(atk_btn),
    .dir_held(dir_held), .grounded(grounded), .hit_stun(hit_stun),
    .attack_active(aa[2]), .atk_state(st[2]), .hitbox_active(hb[2]),
    .anim_restart(rs[2]), .atk_frame(fr[2]));

  // Reference: an attack is a timeline of t ticks since its start.
  typedef struct {
    bit          busy;
    int          t;
    bit          pend;
    attack_state kind;
    int          frame;
    bit          prev;
    bit          rs;
  } mdl_t;

  mdl_t m [3];
  int   cfg_s [3] = '{2, 2, 15};
  bit   cfg_b [3] = '{1'b1, 1'b0, 1'b1};

  int n_cmp = 0;
  int n_bad = 0;
  int nrs [3] = '{0, 0, 0};
  int pc = 0;

  typedef struct {
    logic        act;
    logic        hb;
    logic        rs;
    attack_state st;
    logic [3:0]  fr;
  } tl_t;

  typedef struct {
    logic        g;
    logic        d;
    attack_state k;
  } kv_t;

  tl_t tl [12];
  kv_t kv [4];

  function automatic int ph(int t, int s);
    if (t < s) return 1;
    if (t < s + 3) return 2;
    if (t < s + 7) return 3;
    if (t < s + 9) return 4;
    return 0;
  endfunction

  task automatic check(string nm, logic [15:0] got, logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic mstep(int i);
    int s;
    int cur;
    bit pr;
    bit stt;
    bit cap;
    s = cfg_s[i];
    if (reset) begin
      m[i].busy = 0; m[i].t = 0; m[i].pend = 0; m[i].kind = ATK_NONE;
      m[i].frame = 0; m[i].prev = 0; m[i].rs = 0;
      return;
    end
    cur = m[i].busy ? ph(m[i].t, s) : 0;
    pr = atk_btn && !m[i].prev;
    m[i].prev = atk_btn;
    m[i].rs = 0;
    if (hit_stun) begin
      m[i].busy = 0;
      m[i].pend = 0;
    end else begin
      stt = !m[i].busy && anim_tick && m[i].pend;
      cap = pr && !stt &&
            (cur == 0 || (cfg_b[i] && (cur == 3 || cur == 4)));
      if (anim_tick && cur >= 1 && cur <= 3 && m[i].frame < 15)
        m[i].frame++;
      if (stt) begin
        m[i].busy = 1; m[i].t = 0; m[i].pend = 0; m[i].frame = 0; m[i].rs = 1;
        m[i].kind = !grounded ? AIR : dir_held ? SIDE : NEUTRAL;
      end else if (m[i].busy && anim_tick) begin
        m[i].t++;
        if (m[i].t == s + 9) m[i].busy = 0;
      end
      if (cap) m[i].pend = 1;
    end
  endtask

  function automatic logic [15:0] exp_of(int i);
    int e;
    logic ea;
    attack_state ek;
    e  = m[i].busy ? ph(m[i].t, cfg_s[i]) : 0;
    ea = (e >= 1 && e <= 3);
    ek = ea ? m[i].kind : ATK_NONE;
    return 16'({ea, ek, logic'(e == 2), logic'(m[i].rs), 4'(m[i].frame)});
  endfunction

  task automatic cyc();
    @(posedge clk);
    for (int i = 0; i < 3; i++) mstep(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model_dut%0d", i),
            16'({aa[i], st[i], hb[i], rs[i], fr[i]}), exp_of(i));
      if (rs[i]) nrs[i]++;
    end
  endtask

  task automatic clk_n(int n);
    for (int j = 0; j < n; j++) begin
      anim_tick = (pc == 0);
      pc = (pc + 1) % 4;
      cyc();
    end
    anim_tick = 1'b0;
  endtask

  task automatic press();
    atk_btn = 1'b1;
    clk_n(1);
    atk_btn = 1'b0;
  endtask

  task automatic wait_start(string nm);
    bit f;
    f = 0;
    for (int j = 0; j < 8; j++) begin
      clk_n(1);
      if (rs[0]) begin
        f = 1;
        break;
      end
    end
    check(nm, 16'(f), 16'd1);
  endtask

  task automatic zero_counts();
    for (int i = 0; i < 3; i++) nrs[i] = 0;
  endtask

  initial begin
    tl[0]  = '{1'b1, 1'b0, 1'b1, NEUTRAL,  4'd0};
    tl[1]  = '{1'b1, 1'b0, 1'b0, NEUTRAL,  4'd1};
    tl[2]  = '{1'b1, 1'b1, 1'b0, NEUTRAL,  4'd2};
    tl[3]  = '{1'b1, 1'b1, 1'b0, NEUTRAL,  4'd3};
    tl[4]  = '{1'b1, 1'b1, 1'b0, NEUTRAL,  4'd4};
    tl[5]  = '{1'b1, 1'b0, 1'b0, NEUTRAL,  4'd5};
    tl[6]  = '{1'b1, 1'b0, 1'b0, NEUTRAL,  4'd6};
    tl[7]  = '{1'b1, 1'b0, 1'b0, NEUTRAL,  4'd7};
    tl[8]  = '{1'b1, 1'b0, 1'b0, NEUTRAL,  4'd8};
    tl[9]  = '{1'b0, 1'b0, 1'b0, ATK_NONE, 4'd9};
    tl[10] = '{1'b0, 1'b0, 1'b0, ATK_NONE, 4'd9};
    tl[11] = '{1'b0, 1'b0, 1'b0, ATK_NONE, 4'd9};
    kv[0] = '{1'b1, 1'b0, NEUTRAL};
    kv[1] = '{1'b0, 1'b0, AIR};
    kv[2] = '{1'b0, 1'b1, AIR};
    kv[3] = '{1'b1, 1'b1, SIDE};

    clk_n(3);
    check("reset_out", 16'({aa[0], st[0], hb[0], rs[0], fr[0]}), 16'd0);
    reset = 1'b0;
    clk_n(4);

    // Basic timeline, one row per tick after the start tick.
    press();
    wait_start("t1_start");
    for (int k = 0; k < 12; k++) begin
      if (k > 0) clk_n(4);
      check($sformatf("t1_tick%0d", k),
            16'({aa[0], hb[0], rs[0], st[0], fr[0]}),
            16'({tl[k].act, tl[k].hb, tl[k].rs, tl[k].st, tl[k].fr}));
    end
    clk_n(120);

    // Attack kind selection, latched for the whole attack.
    for (int k = 0; k < 4; k++) begin
      grounded = kv[k].g;
      dir_held = kv[k].d;
      press();
      wait_start($sformatf("t2_start%0d", k));
      check($sformatf("t2_kind%0d", k), 16'(st[0]), 16'(kv[k].k));
      grounded = ~kv[k].g;
      clk_n(8);
      check($sformatf("t2_hold%0d", k), 16'(st[0]), 16'(kv[k].k));
      grounded = 1'b1;
      dir_held = 1'b0;
      clk_n(120);
    end

    // Press in ACTIVE dropped, press in RECOVERY buffered.
    zero_counts();
    press();
    wait_start("t3_start");
    clk_n(11);
    press();
    clk_n(11);
    press();
    clk_n(120);
    check("t3_buf_attacks", 16'(nrs[0]), 16'd2);
    check("t3_nobuf_attacks", 16'(nrs[1]), 16'd1);
    clk_n(120);

    // hit_stun on a tick during ACTIVE.
    press();
    wait_start("t4_start");
    clk_n(11);
    hit_stun = 1'b1;
    clk_n(1);
    hit_stun = 1'b0;
    check("t4_abort", 16'({aa[0], hb[0], st[0]}), 16'd0);
    clk_n(120);

    // hit_stun in COOLDOWN clears a buffered press.
    zero_counts();
    press();
    wait_start("t4b_start");
    clk_n(23);
    press();
    clk_n(15);
    hit_stun = 1'b1;
    clk_n(1);
    hit_stun = 1'b0;
    clk_n(120);
    check("t4b_no_rerun", 16'(nrs[0]), 16'd1);

    // Asynchronous reset in the middle of STARTUP.
    press();
    wait_start("t5_start");
    clk_n(2);
    #3;
    reset = 1'b1;
    #1;
    check("t5_async", 16'({aa[0], st[0], hb[0], rs[0], fr[0]}), 16'd0);
    clk_n(2);
    reset = 1'b0;
    clk_n(2);
    press();
    wait_start("t5_restart");
    check("t5_clean", 16'({st[0], fr[0]}), 16'({NEUTRAL, 4'd0}));
    clk_n(120);

    // Held button fires once; long startup saturates the frame count.
    zero_counts();
    atk_btn = 1'b1;
    clk_n(40);
    atk_btn = 1'b0;
    clk_n(120);
    check("t6_one_attack", 16'(nrs[0]), 16'd1);
    check("t6_sat15", 16'(fr[2]), 16'd15);
    check("t6_frame9", 16'(fr[0]), 16'd9);

    // Random traffic against the model.
    for (int j = 0; j < 3000; j++) begin
      atk_btn   = ($urandom_range(0, 2) == 0);
      anim_tick = ($urandom_range(0, 2) == 0);
      hit_stun  = ($urandom_range(0, 79) == 0);
      grounded  = ($urandom_range(0, 3) != 0);
      dir_held  = $urandom_range(0, 1);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
